// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - shared op encodings, states and default latencies for the HI/LO unit
package xalu_pkg;

  // Op encodings shared with the instruction decoder
  typedef enum logic [2:0] {
    XALU_NOP   = 3'd0,
    XALU_MULT  = 3'd1,
    XALU_MULTU = 3'd2,
    XALU_DIV   = 3'd3,
    XALU_DIVU  = 3'd4,
    XALU_MTHI  = 3'd5,
    XALU_MTLO  = 3'd6,
    XALU_RSVD  = 3'd7
  } xalu_op_e;

  typedef enum logic {
    XALU_IDLE = 1'b0,
    XALU_RUN  = 1'b1
  } xalu_state_e;

  localparam int unsigned XALU_MULT_LAT_DEF = 5;
  localparam int unsigned XALU_DIV_LAT_DEF  = 10;

endpackage

// File: rtl/xalu_if.sv
// rtl/xalu_if.sv - E-stage request and HI/LO result bundle for the multiply/divide unit
interface xalu_if;
  import xalu_pkg::*;

  logic        start;
  xalu_op_e    op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] xalu_out;

  modport master (
    output start, op, a, b, sel_hi,
    input  busy, hi, lo, xalu_out
  );

  modport slave (
    input  start, op, a, b, sel_hi,
    output busy, hi, lo, xalu_out
  );

endinterface

// File: rtl/xalu.sv
// rtl/xalu.sv - MIPS HI/LO multiply/divide unit with a fixed-latency busy window
module xalu
  import xalu_pkg::*;
#(
  parameter int unsigned MULT_LAT = XALU_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = XALU_DIV_LAT_DEF
) (
  input logic   clk,
  input logic   rst_n,
  xalu_if.slave bus
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  xalu_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic        div_zero;
  logic        div_ovf;
  logic [31:0] divisor;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [63:0] result;

  // Behavioural multiply/divide; the divisor is forced to 1 for b==0 and for
  // the INT_MIN/-1 case, which also yields the required {HI=0, LO=0x80000000}
  always_comb begin
    div_zero = (bus.b == 32'd0);
    div_ovf  = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    divisor  = (div_zero || div_ovf) ? 32'd1 : bus.b;
    prod_s   = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u   = {32'd0, bus.a} * {32'd0, bus.b};
    quot_s   = $signed(bus.a) / $signed(divisor);
    rem_s    = $signed(bus.a) % $signed(divisor);
    quot_u   = bus.a / divisor;
    rem_u    = bus.a % divisor;
    result   = {hi_q, lo_q};
    case (bus.op)
      XALU_MULT:  result = prod_s;
      XALU_MULTU: result = prod_u;
      XALU_DIV:   result = div_zero ? {hi_q, lo_q} : {rem_s, quot_s};
      XALU_DIVU:  result = div_zero ? {hi_q, lo_q} : {rem_u, quot_u};
      default:    result = {hi_q, lo_q};
    endcase
  end

  // Next-state: accept ops only in IDLE, count down RUN, commit pending at the end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      XALU_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            XALU_MULT, XALU_MULTU, XALU_DIV, XALU_DIVU: begin
              pend_hi_d = result[63:32];
              pend_lo_d = result[31:0];
              cnt_d     = (bus.op == XALU_MULT || bus.op == XALU_MULTU) ? MULT_CNT : DIV_CNT;
              state_d   = XALU_RUN;
            end
            XALU_MTHI: hi_d = bus.a;
            XALU_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      XALU_RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = XALU_IDLE;
        end
      end
      default: state_d = XALU_IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= XALU_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy     = (state_q == XALU_RUN);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.xalu_out = bus.sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_xalu.sv
// tb/tb_xalu.sv - scoreboard bench for the HI/LO multiply/divide unit
module tb_xalu;
  import xalu_pkg::*;

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   mon_busy;
  logic seen_busy;
  exp_t exp_q[$];

  xalu_if bus();

  xalu #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every busy window that closes pops one expectation
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_busy = 0;
    end else if (bus.busy) begin
      mon_busy++;
    end else if (mon_busy != 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_completion: busy window of %0d cycles with no expectation", mon_busy);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_lat"}, 32'(mon_busy), 32'(e.lat));
        chk({e.name, "_hi"}, bus.hi, e.hi);
        chk({e.name, "_lo"}, bus.lo, e.lo);
      end
      mon_busy = 0;
    end
  end

  task automatic push(input string name, input int lat, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name; e.lat = lat; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
  endtask

  task automatic do_op(input xalu_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    if (bus.busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: busy still 1 expected 0", name);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    bus.start = 1'b0; bus.op = XALU_NOP; bus.a = '0; bus.b = '0; bus.sel_hi = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_out", bus.xalu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push("mult_m1", 5, 32'h0000_0000, 32'h0000_0001);
    do_op(XALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("mult_m1");

    push("multu_max", 5, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(XALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_max");

    push("div_m7_2", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(XALU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_m7_2");

    push("divu_by0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(XALU_DIVU, 32'd7, 32'd0);
    wait_idle("divu_by0");

    push("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
    do_op(XALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    // -100 / 7: quotient -14, remainder -2; MTHI mid-run must be dropped
    push("div_mthi", 10, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    do_op(XALU_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op = XALU_MTHI; bus.a = 32'h1234_5678; bus.sel_hi = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_hi_old", bus.hi, 32'd0);
    chk("mid_out_old", bus.xalu_out, 32'd0);
    wait_idle("div_mthi");

    // Ops that must do nothing
    do_op(XALU_NOP, 32'd1, 32'd1);
    chk("nop_busy", 32'(bus.busy), 32'd0);
    do_op(XALU_RSVD, 32'd1, 32'd1);
    chk("rsvd_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.op = XALU_MULT; bus.a = 32'd9; bus.b = 32'd9;
    repeat (2) @(negedge clk);
    chk("nostart_busy", 32'(bus.busy), 32'd0);
    chk("noop_hi", bus.hi, 32'hFFFF_FFFE);
    chk("noop_lo", bus.lo, 32'hFFFF_FFF2);

    // MTLO / MTHI in IDLE write at the start edge
    @(negedge clk);
    bus.start = 1'b1; bus.op = XALU_MTLO; bus.a = 32'hCAFE_BABE; bus.sel_hi = 1'b0;
    @(posedge clk);
    #1;
    chk("mtlo_lo", bus.lo, 32'hCAFE_BABE);
    chk("mtlo_out", bus.xalu_out, 32'hCAFE_BABE);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.op = XALU_MTHI; bus.a = 32'h0BAD_F00D; bus.sel_hi = 1'b1;
    @(posedge clk);
    #1;
    chk("mthi_hi", bus.hi, 32'h0BAD_F00D);
    chk("mthi_out", bus.xalu_out, 32'h0BAD_F00D);
    chk("mthi_lo_kept", bus.lo, 32'hCAFE_BABE);
    @(negedge clk);
    bus.start = 1'b0;

    // Reset mid-MULT: clears immediately, pending result never lands
    do_op(XALU_MULT, 32'd3, 32'd5);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    #1 rst_n = 1'b1;
    seen_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy) seen_busy = 1'b1;
    end
    chk("abort_no_busy", 32'(seen_busy), 32'd0);
    chk("abort_hi_late", bus.hi, 32'd0);
    chk("abort_lo_late", bus.lo, 32'd0);

    // First start after reset release is honoured on the first edge
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push("post_rst", 5, 32'd0, 32'd42);
    bus.start = 1'b1; bus.op = XALU_MULTU; bus.a = 32'd6; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_rst_busy", 32'(bus.busy), 32'd1);
    wait_idle("post_rst");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
